pwm_duty_sequencer: RTL and testbench

Control block that sits in front of the PWM generator and owns its duty-cycle value. It debounces the two user buttons (`btn_increase`, `btn_decrease`) and keeps a saturating target duty in 10 % steps. The applied duty slews toward the target by a bounded amount, one update per PWM period, so the generator only sees duty changes at period boundaries and never gets a glitched or partial period.

---
 rtl/pwm_ctrl_pkg.sv | 13 +
 rtl/btn_debounce.sv | 44 ++++
 rtl/pwm_duty_sequencer.sv | 109 ++++++++++
 tb/tb_pwm_duty_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ctrl_pkg.sv
// Shared types and default constants for the PWM duty control path.
package pwm_ctrl_pkg;

  localparam int PCT_MAX  = 100;
  localparam int PCT_STEP = 10;
  localparam int PCT_W    = 7;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } slew_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus counter debounce; emits a one-cycle press pulse
// on each accepted 0->1 transition of the stable level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // Level held long enough: accept it; only a rising acceptance is a press.
        stable <= sync2;
        cnt    <= '0;
        press  <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Owns the PWM duty: debounced buttons move a saturating target, and the
// applied duty slews toward it by at most SLEW once per PWM period.
module pwm_duty_sequencer
  import pwm_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STEP            = PCT_STEP,
  parameter int SLEW            = 10,
  parameter int MAX_DUTY        = PCT_MAX,
  parameter int RESET_DUTY      = 50,
  parameter int DUTY_W          = PCT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_increase,
  input  logic              btn_decrease,
  input  logic              period_end,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_update,
  output logic [DUTY_W-1:0] target,
  output logic              busy,
  output logic              at_max,
  output logic              at_min
);

  localparam logic [DUTY_W-1:0] STEP_V  = DUTY_W'(STEP);
  localparam logic [DUTY_W-1:0] SLEW_V  = DUTY_W'(SLEW);
  localparam logic [DUTY_W-1:0] MAX_V   = DUTY_W'(MAX_DUTY);
  localparam logic [DUTY_W-1:0] RESET_V = DUTY_W'(RESET_DUTY);

  logic              inc_press;
  logic              dec_press;
  logic [DUTY_W-1:0] target_next;
  logic [DUTY_W-1:0] duty_next;
  logic [DUTY_W-1:0] gap;
  logic [DUTY_W-1:0] step_amt;
  slew_state_t       state;
  slew_state_t       state_next;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_increase),
    .press   (inc_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_decrease),
    .press   (dec_press)
  );

  // Saturating target; comparisons come first so neither side can wrap.
  always_comb begin
    target_next = target;
    if (inc_press && !dec_press) begin
      target_next = ((MAX_V - target) <= STEP_V) ? MAX_V : target + STEP_V;
    end else if (dec_press && !inc_press) begin
      target_next = (target <= STEP_V) ? '0 : target - STEP_V;
    end
  end

  // Duty steps toward the current (pre-update) target only on period_end.
  always_comb begin
    gap       = (target >= duty) ? target - duty : duty - target;
    step_amt  = (gap < SLEW_V) ? gap : SLEW_V;
    duty_next = duty;
    if (state == RAMP && period_end) begin
      duty_next = (target > duty) ? duty + step_amt : duty - step_amt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (target_next != duty) state_next = RAMP;
      RAMP:    if (duty_next == target_next) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target      <= RESET_V;
      duty        <= RESET_V;
      duty_update <= 1'b0;
    end else begin
      target      <= target_next;
      duty        <= duty_next;
      duty_update <= (duty_next != duty);
    end
  end

  always_comb begin
    busy   = (state == RAMP);
    at_max = (target == MAX_V);
    at_min = (target == '0);
  end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Bench for pwm_duty_sequencer: a default instance and a SLEW=3 instance share
// stimulus and are compared against an arithmetic model of target and duty.
module tb_pwm_duty_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_increase;
  logic       btn_decrease;
  logic       period_end;
  logic [6:0] duty_a, target_a, duty_b, target_b;
  logic       upd_a, busy_a, max_a, min_a;
  logic       upd_b, busy_b, max_b, min_b;

  int checks = 0;
  int errors = 0;
  int m_t, m_da, m_db;

  always #5 clk = ~clk;

  pwm_duty_sequencer dut_a (
    .clk (clk), .rst (rst), .btn_increase (btn_increase), .btn_decrease (btn_decrease),
    .period_end (period_end), .duty (duty_a), .duty_update (upd_a), .target (target_a),
    .busy (busy_a), .at_max (max_a), .at_min (min_a)
  );

  pwm_duty_sequencer #(.SLEW(3)) dut_b (
    .clk (clk), .rst (rst), .btn_increase (btn_increase), .btn_decrease (btn_decrease),
    .period_end (period_end), .duty (duty_b), .duty_update (upd_b), .target (target_b),
    .busy (busy_b), .at_max (max_b), .at_min (min_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int slew_step(input int d, input int t, input int s);
    int diff;
    diff = (t > d) ? t - d : d - t;
    if (diff > s) diff = s;
    return (t > d) ? d + diff : d - diff;
  endfunction

  function automatic int apply_press(input int t, input bit inc, input bit dec);
    if (inc && !dec) return (t + 10 > 100) ? 100 : t + 10;
    if (dec && !inc) return (t < 10) ? 0 : t - 10;
    return t;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "_target_a"}, 32'(target_a), m_t);
    chk({tag, "_duty_a"},   32'(duty_a),   m_da);
    chk({tag, "_busy_a"},   32'(busy_a),   32'(m_da != m_t));
    chk({tag, "_atmax_a"},  32'(max_a),    32'(m_t == 100));
    chk({tag, "_atmin_a"},  32'(min_a),    32'(m_t == 0));
    chk({tag, "_target_b"}, 32'(target_b), m_t);
    chk({tag, "_duty_b"},   32'(duty_b),   m_db);
    chk({tag, "_busy_b"},   32'(busy_b),   32'(m_db != m_t));
    chk({tag, "_atmax_b"},  32'(max_b),    32'(m_t == 100));
    chk({tag, "_atmin_b"},  32'(min_b),    32'(m_t == 0));
  endtask

  // Press with hold >= 7; target must still be old after edge 6 and new after edge 7.
  task automatic do_press(input bit inc, input bit dec, input int hold, input bit pe_on_update);
    int  old_t;
    bit  ua, ub;
    old_t = m_t;
    @(negedge clk);
    btn_increase = inc;
    btn_decrease = dec;
    for (int i = 1; i <= 6; i++) @(negedge clk);
    chk("latency_old_a", 32'(target_a), old_t);
    chk("latency_old_b", 32'(target_b), old_t);
    if (pe_on_update) period_end = 1'b1;
    @(negedge clk);
    period_end = 1'b0;
    if (pe_on_update) begin
      ua   = (m_da != old_t);
      ub   = (m_db != old_t);
      m_da = slew_step(m_da, old_t, 10);
      m_db = slew_step(m_db, old_t, 3);
      chk("press_pe_upd_a", 32'(upd_a), 32'(ua));
      chk("press_pe_upd_b", 32'(upd_b), 32'(ub));
    end
    m_t = apply_press(old_t, inc, dec);
    check_state("press");
    repeat (hold - 7) @(negedge clk);
    btn_increase = 1'b0;
    btn_decrease = 1'b0;
    repeat (10) @(negedge clk);
    check_state("release");
  endtask

  task automatic do_period_end();
    bit ua, ub;
    @(negedge clk);
    period_end = 1'b1;
    @(negedge clk);
    period_end = 1'b0;
    ua   = (m_da != m_t);
    ub   = (m_db != m_t);
    m_da = slew_step(m_da, m_t, 10);
    m_db = slew_step(m_db, m_t, 3);
    chk("pe_upd_a", 32'(upd_a), 32'(ua));
    chk("pe_upd_b", 32'(upd_b), 32'(ub));
    check_state("period_end");
    @(negedge clk);
    chk("pe_upd_drop_a", 32'(upd_a), 0);
    chk("pe_upd_drop_b", 32'(upd_b), 0);
  endtask

  task automatic do_glitch(input bit on_inc, input int len);
    @(negedge clk);
    if (on_inc) btn_increase = 1'b1; else btn_decrease = 1'b1;
    repeat (len) @(negedge clk);
    btn_increase = 1'b0;
    btn_decrease = 1'b0;
    @(negedge clk);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    m_t  = 50;
    m_da = 50;
    m_db = 50;
    check_state("async_rst");
    chk("async_rst_upd_a", 32'(upd_a), 0);
    chk("async_rst_upd_b", 32'(upd_b), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_state("post_rst");
  endtask

  initial begin
    rst          = 1'b1;
    btn_increase = 1'b0;
    btn_decrease = 1'b0;
    period_end   = 1'b0;
    m_t  = 50;
    m_da = 50;
    m_db = 50;
    #1;
    check_state("reset");
    chk("reset_upd_a", 32'(upd_a), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_state("after_reset");

    // Single press, then one period finishes the default ramp; SLEW=3 reaches 56.
    do_press(1'b1, 1'b0, 10, 1'b0);
    do_period_end();
    do_period_end();
    // Reverse mid-ramp at duty 56 and settle at 50.
    do_press(1'b0, 1'b1, 9, 1'b0);
    do_period_end();
    do_period_end();
    do_period_end();
    // 50 -> 60 with SLEW=3: 53, 56, 59, 60.
    do_press(1'b1, 1'b0, 8, 1'b0);
    for (int i = 0; i < 4; i++) do_period_end();

    // Short pulse and a burst of 1-cycle glitches must be rejected.
    do_glitch(1'b1, 3);
    for (int i = 0; i < 5; i++) do_glitch(1'b1, 1);
    for (int i = 0; i < 3; i++) do_glitch(1'b0, 1);
    repeat (10) @(negedge clk);
    check_state("glitch");

    // Saturate high, then low with no wrap.
    for (int i = 0; i < 6; i++) do_press(1'b1, 1'b0, 7, 1'b0);
    for (int i = 0; i < 11; i++) do_press(1'b0, 1'b1, 7, 1'b0);
    for (int i = 0; i < 3; i++) do_period_end();

    // Simultaneous presses, and a press coinciding with period_end.
    do_press(1'b1, 1'b1, 8, 1'b0);
    do_press(1'b1, 1'b0, 8, 1'b1);
    do_press(1'b1, 1'b0, 8, 1'b1);

    // Asynchronous reset mid-ramp: default at 60, SLEW=3 at 56 toward 60.
    async_reset();
    do_press(1'b1, 1'b0, 8, 1'b0);
    do_period_end();
    do_period_end();
    async_reset();

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0: do_press(1'b1, 1'b0, $urandom_range(7, 12), 1'b0);
        1: do_press(1'b0, 1'b1, $urandom_range(7, 12), 1'b0);
        2: do_press(1'b1, 1'b1, $urandom_range(7, 12), 1'b0);
        3: do_period_end();
        4: begin
          do_glitch(1'($urandom_range(0, 1)), $urandom_range(1, 3));
          repeat (10) @(negedge clk);
          check_state("rand_glitch");
        end
        default: do_press(1'($urandom_range(0, 1)), 1'b0, $urandom_range(7, 12), 1'b1);
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
